// File: rtl/fpga_io_pkg.sv
// Shared definitions for the FPGA I/O event hub: register map and identification constants.
package fpga_io_pkg;

  typedef enum logic [2:0] {
    AddrDataIn  = 3'd0,
    AddrLed     = 3'd1,
    AddrEdgeCap = 3'd2,
    AddrIrqMask = 3'd3,
    AddrRiseEn  = 3'd4,
    AddrFallEn  = 3'd5,
    AddrParams  = 3'd6,
    AddrRsvd    = 3'd7
  } reg_addr_e;

  localparam logic [7:0] ParamsVersion = 8'h01;

  // EDGE_CAP is write-1-to-clear; a capture landing in the same cycle as its clear wins,
  // so software never loses an event that arrives while it acknowledges an older one.

endpackage

// File: rtl/fpga_io_event_hub_if.sv
// Lightweight Avalon-MM slave bundle between the HPS bridge and the I/O hub.
interface fpga_io_event_hub_if;

  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );

endinterface

// File: rtl/fpga_io_debounce.sv
// One-bit synchroniser plus stability-counter debouncer; toggle_o flags the cycle deb_o flips.
module fpga_io_debounce #(
  parameter int unsigned DebCycles = 50000,
  parameter logic        RstVal    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic deb_o,
  output logic toggle_o
);

  localparam int unsigned CntW = (DebCycles > 1) ? $clog2(DebCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebCycles - 1);

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the settled value restarts the stability window.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntMax) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= RstVal;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o    = deb_q;
  assign toggle_o = (deb_d != deb_q);

endmodule

// File: rtl/fpga_io_event_hub.sv
// HPS-visible peripheral hub: debounced buttons/switches, edge capture with IRQ, LED register
// and the packed STM hardware-event word.
module fpga_io_event_hub
  import fpga_io_pkg::*;
#(
  parameter int unsigned N_BTN      = 2,
  parameter int unsigned N_SW       = 4,
  parameter int unsigned N_LED      = 4,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter logic        BTN_RST    = 1'b1,
  parameter int unsigned EVT_W      = 28
) (
  input  logic                 fpga_clk_50,
  input  logic                 hps_fpga_reset_n,
  input  logic [N_BTN-1:0]     fpga_button_pio,
  input  logic [N_SW-1:0]      fpga_dipsw_pio,
  output logic [N_LED-1:0]     fpga_led_pio,
  fpga_io_event_hub_if.slave   avs,
  output logic                 irq,
  output logic [EVT_W-1:0]     stm_hw_events
);

  localparam int unsigned NI    = N_BTN + N_SW;
  localparam int unsigned PackW = N_SW + N_LED + N_BTN;

  logic [NI-1:0] raw_in;
  logic [NI-1:0] deb;
  logic [NI-1:0] deb_toggle;

  assign raw_in = {fpga_dipsw_pio, fpga_button_pio};

  for (genvar gi = 0; gi < NI; gi++) begin : g_deb
    fpga_io_debounce #(
      .DebCycles (DEB_CYCLES),
      .RstVal    ((gi < N_BTN) ? BTN_RST : 1'b0)
    ) u_deb (
      .clk_i    (fpga_clk_50),
      .rst_ni   (hps_fpga_reset_n),
      .raw_i    (raw_in[gi]),
      .deb_o    (deb[gi]),
      .toggle_o (deb_toggle[gi])
    );
  end

  logic [N_LED-1:0] led_q, led_d;
  logic [NI-1:0]    edge_cap_q, edge_cap_d;
  logic [NI-1:0]    irq_mask_q, irq_mask_d;
  logic [NI-1:0]    rise_en_q, rise_en_d;
  logic [NI-1:0]    fall_en_q, fall_en_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      rd_mux;
  logic [NI-1:0]    edge_set;
  logic [NI-1:0]    edge_clr;
  reg_addr_e        addr;

  assign addr = reg_addr_e'(avs.avs_address);

  // The toggle pulse coincides with the deb update, so deb still holds the old level here.
  assign edge_set = (deb_toggle & ~deb & rise_en_q) | (deb_toggle & deb & fall_en_q);

  always_comb begin
    led_d      = led_q;
    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    edge_clr   = '0;
    if (avs.avs_write) begin
      unique case (addr)
        AddrLed:     led_d      = avs.avs_writedata[N_LED-1:0];
        AddrEdgeCap: edge_clr   = avs.avs_writedata[NI-1:0];
        AddrIrqMask: irq_mask_d = avs.avs_writedata[NI-1:0];
        AddrRiseEn:  rise_en_d  = avs.avs_writedata[NI-1:0];
        AddrFallEn:  fall_en_d  = avs.avs_writedata[NI-1:0];
        default: ;
      endcase
    end
    edge_cap_d = (edge_cap_q & ~edge_clr) | edge_set;
    irq_d      = |(edge_cap_q & irq_mask_q);
  end

  // Read mux sees register values before any same-cycle write lands.
  always_comb begin
    rd_mux = '0;
    unique case (addr)
      AddrDataIn:  rd_mux = 32'(deb);
      AddrLed:     rd_mux = 32'(led_q);
      AddrEdgeCap: rd_mux = 32'(edge_cap_q);
      AddrIrqMask: rd_mux = 32'(irq_mask_q);
      AddrRiseEn:  rd_mux = 32'(rise_en_q);
      AddrFallEn:  rd_mux = 32'(fall_en_q);
      AddrParams:  rd_mux = {8'(N_LED), 8'(N_SW), 8'(N_BTN), ParamsVersion};
      default:     rd_mux = '0;
    endcase
    rdata_d = avs.avs_read ? rd_mux : rdata_q;
  end

  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      led_q      <= '0;
      edge_cap_q <= '0;
      irq_mask_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '1;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      led_q      <= led_d;
      edge_cap_q <= edge_cap_d;
      irq_mask_q <= irq_mask_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
    end
  end

  logic [PackW-1:0] evt_pack;
  assign evt_pack = {deb[NI-1:N_BTN], led_q, deb[N_BTN-1:0]};

  assign stm_hw_events    = EVT_W'(evt_pack);
  assign fpga_led_pio     = led_q;
  assign irq              = irq_q;
  assign avs.avs_readdata = rdata_q;

  logic unused_wdata;
  assign unused_wdata = ^avs.avs_writedata;

endmodule
